// File: rtl/sgd_grad_bcast_tree_if.sv
// Sample-in / gradient-out bundle for the SGD gradient broadcast tree.
// The slave modport is the design side; the master modport is the driver side.
interface sgd_grad_bcast_tree_if #(
    parameter int TREE_WIDTH = 8,
    parameter int FIFO_AW    = 2
);
    logic signed [31:0]    dot_in;
    logic signed [31:0]    label_in;
    logic                  dot_valid;
    logic                  dot_ready;
    logic [4:0]            step_shift;
    logic [TREE_WIDTH-1:0] lane_enable;
    logic signed [31:0]    g_output [TREE_WIDTH-1:0];
    logic                  g_output_valid;
    logic                  g_output_ready;
    logic [FIFO_AW:0]      fifo_count;
    logic                  sat_flag;

    modport slave (
        input  dot_in, label_in, dot_valid, step_shift, lane_enable, g_output_ready,
        output dot_ready, g_output, g_output_valid, fifo_count, sat_flag
    );

    modport master (
        output dot_in, label_in, dot_valid, step_shift, lane_enable, g_output_ready,
        input  dot_ready, g_output, g_output_valid, fifo_count, sat_flag
    );
endinterface

// File: rtl/sgd_grad_bcast_tree.sv
// SGD gradient broadcast: scales (dot - label) by an arithmetic right shift,
// saturates to 32 bits, queues the scalar in a small FIFO and fans it out
// through a registered copy tree to TREE_WIDTH bank lanes.
module sgd_grad_bcast_tree #(
    parameter int TREE_DEPTH = 3,
    parameter int TREE_WIDTH = 2 ** TREE_DEPTH,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic clk,
    input  logic rst_n,
    sgd_grad_bcast_tree_if.slave bus
);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic signed [32:0] diff;
    logic signed [32:0] shifted;
    logic signed [31:0] sat_val;
    logic               sat_hit;

    logic signed [31:0]  mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                sat_q;
    logic                dot_ready_w;
    logic                push, pop;
    logic signed [31:0]  rd_data;

    // Scale and saturate the incoming error; 33 bits cannot overflow on the subtract.
    always_comb begin
        diff    = {bus.dot_in[31], bus.dot_in} - {bus.label_in[31], bus.label_in};
        shifted = diff >>> bus.step_shift;
        sat_hit = shifted[32] != shifted[31];
        if (sat_hit) begin
            sat_val = shifted[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            sat_val = shifted[31:0];
        end
    end

    // Ready looks only at the registered count; a same-cycle pop does not open a slot.
    assign dot_ready_w = rst_n && (count_q != FULL_CNT);
    assign push        = bus.dot_valid && dot_ready_w;
    assign pop         = bus.g_output_ready && (count_q != '0);
    assign rd_data     = mem_q[rd_ptr_q];

    // Occupancy: push-only up, pop-only down, both or neither unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sat_val;
        end
    end

    // FIFO pointers, occupancy and the sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (push && sat_hit) begin
                sat_q <= 1'b1;
            end
        end
    end

    // Broadcast tree: stage k holds 2^(k+1) copies, each fed by its parent copy.
    // Data and mask only load on a valid entry so the outputs hold between entries.
    for (genvar k = 0; k < TREE_DEPTH; k++) begin : g_stage
        localparam int N = 2 ** (k + 1);
        logic signed [31:0]    data_q   [N];
        logic signed [31:0]    par_data [N];
        logic                  vld_q;
        logic                  par_vld;
        logic [TREE_WIDTH-1:0] mask_q;
        logic [TREE_WIDTH-1:0] par_mask;

        if (k == 0) begin : g_root
            assign par_vld  = pop;
            assign par_mask = bus.lane_enable;
            for (genvar c = 0; c < N; c++) begin : g_cp
                assign par_data[c] = rd_data;
            end
        end else begin : g_node
            assign par_vld  = g_stage[k-1].vld_q;
            assign par_mask = g_stage[k-1].mask_q;
            for (genvar c = 0; c < N; c++) begin : g_cp
                assign par_data[c] = g_stage[k-1].data_q[c/2];
            end
        end

        // One pipeline step of the tree; valid always advances, never stalls.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                mask_q <= '0;
                for (int i = 0; i < N; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                vld_q <= par_vld;
                if (par_vld) begin
                    mask_q <= par_mask;
                    for (int i = 0; i < N; i++) begin
                        data_q[i] <= par_data[i];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < TREE_WIDTH; i++) begin : g_lane
        assign bus.g_output[i] = g_stage[TREE_DEPTH-1].mask_q[i] ? g_stage[TREE_DEPTH-1].data_q[i] : '0;
    end

    assign bus.g_output_valid = g_stage[TREE_DEPTH-1].vld_q;
    assign bus.dot_ready      = dot_ready_w;
    assign bus.fifo_count     = count_q;
    assign bus.sat_flag       = sat_q;
endmodule

// File: tb/tb_sgd_grad_bcast_tree.sv
// Bench for sgd_grad_bcast_tree: directed vector table, hand-written
// backpressure / reset / push-pop sequences, and a randomized run, all
// shadowed cycle by cycle by a queue-based reference model.
module tb_sgd_grad_bcast_tree;
    localparam int TD = 3;
    localparam int TW = 8;
    localparam int FD = 4;

    logic clk;
    logic rst_n;

    sgd_grad_bcast_tree_if #(.TREE_WIDTH(TW), .FIFO_AW(2)) bus ();

    sgd_grad_bcast_tree #(.TREE_DEPTH(TD), .TREE_WIDTH(TW), .FIFO_DEPTH(FD), .FIFO_AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dot;
        int         lbl;
        int         sh;
        logic [7:0] mask;
        int         exp;
        bit         sat;
    } vec_t;

    typedef struct {
        int         due;
        int         val;
        logic [7:0] mask;
    } pend_t;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    int    mq[$];
    pend_t pend[$];
    bit    m_sat  = 0;

    bit    obs_valid;
    bit    obs_dut_acc;
    int    obs_lane [TW];

    task automatic check(string name, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference scaling from the arithmetic definition, in 64-bit.
    function automatic int ref_scale(int d, int l, int s, output bit sat);
        longint df, sh;
        df  = longint'(d) - longint'(l);
        sh  = df >>> s;
        sat = 1'b0;
        if (sh > 64'sd2147483647) begin
            sh = 64'sd2147483647;
            sat = 1'b1;
        end else if (sh < -64'sd2147483648) begin
            sh = -64'sd2147483648;
            sat = 1'b1;
        end
        return int'(sh);
    endfunction

    // One clock: compare DUT against the model at negedge, then advance the model.
    task automatic tick();
        bit    exp_v, acc, pop_m, s;
        pend_t e;
        int    v;
        @(negedge clk);
        exp_v = (pend.size() > 0) && (pend[0].due == cyc);
        check("dot_ready", bus.dot_ready, mq.size() != FD);
        check("fifo_count", bus.fifo_count, mq.size());
        check("sat_flag", bus.sat_flag, m_sat);
        check("g_output_valid", bus.g_output_valid, exp_v);
        obs_valid   = bus.g_output_valid;
        obs_dut_acc = bus.dot_valid && bus.dot_ready;
        for (int i = 0; i < TW; i++) obs_lane[i] = bus.g_output[i];
        if (exp_v) begin
            e = pend.pop_front();
            for (int i = 0; i < TW; i++)
                check($sformatf("lane%0d", i), bus.g_output[i], e.mask[i] ? e.val : 0);
        end
        acc   = bus.dot_valid && (mq.size() != FD);
        pop_m = bus.g_output_ready && (mq.size() > 0);
        if (pop_m) begin
            v = mq.pop_front();
            pend.push_back('{cyc + TD, v, bus.lane_enable});
        end
        if (acc) begin
            mq.push_back(ref_scale(bus.dot_in, bus.label_in, int'(bus.step_shift), s));
            if (s) m_sat = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_dot_ready", bus.dot_ready, 0);
        check("rst_valid", bus.g_output_valid, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_sat", bus.sat_flag, 0);
        for (int i = 0; i < TW; i++) check($sformatf("rst_lane%0d", i), bus.g_output[i], 0);
        mq.delete();
        pend.delete();
        m_sat = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs [9];

    initial begin
        int lat, nv, k;
        int snap [TW];

        vecs[0] = '{1000, 200, 3, 8'hFF, 100, 1'b0};
        vecs[1] = '{-7, 0, 1, 8'hFF, -4, 1'b0};
        vecs[2] = '{7, 0, 1, 8'hFF, 3, 1'b0};
        vecs[3] = '{42, 0, 0, 8'hA5, 42, 1'b0};
        vecs[4] = '{0, 1, 0, 8'hFF, -1, 1'b0};
        vecs[5] = '{-1, 0, 31, 8'hFF, -1, 1'b0};
        vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 0, 8'hFF, 32'h7FFF_FFFF, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 0, 8'hFF, 32'h8000_0000, 1'b1};
        vecs[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 1, 8'hFF, 32'h7FFF_FFFF, 1'b1};

        bus.dot_in = 0; bus.label_in = 0; bus.dot_valid = 0;
        bus.step_shift = 0; bus.lane_enable = '1; bus.g_output_ready = 0;
        rst_n = 1'b0;
        do_reset();

        // Directed vectors: single sample each, latency and lane mask checked.
        foreach (vecs[n]) begin
            bus.dot_in = vecs[n].dot; bus.label_in = vecs[n].lbl;
            bus.step_shift = 5'(vecs[n].sh); bus.lane_enable = vecs[n].mask;
            bus.g_output_ready = 1; bus.dot_valid = 1;
            tick();
            bus.dot_valid = 0;
            tick();
            bus.lane_enable = ~vecs[n].mask;
            lat = -1; nv = 0;
            for (int j = 3; j <= 10; j++) begin
                tick();
                if (obs_valid) begin
                    nv++;
                    if (lat < 0) lat = j - 1;
                    snap = obs_lane;
                end
            end
            check($sformatf("vec%0d_latency", n), lat, 4);
            check($sformatf("vec%0d_pulses", n), nv, 1);
            for (int i = 0; i < TW; i++)
                check($sformatf("vec%0d_lane%0d", n, i), snap[i], vecs[n].mask[i] ? vecs[n].exp : 0);
            check($sformatf("vec%0d_sat", n), bus.sat_flag, vecs[n].sat);
            check($sformatf("vec%0d_count", n), bus.fifo_count, 0);
        end

        // Backpressure: five back-to-back samples against a stalled consumer.
        bus.g_output_ready = 0; bus.lane_enable = '1; bus.step_shift = 0; bus.label_in = 0;
        for (int i = 0; i < 5; i++) begin
            bus.dot_in = 100 + i; bus.dot_valid = 1;
            tick();
        end
        check("bp_full_count", bus.fifo_count, 4);
        check("bp_full_ready", bus.dot_ready, 0);
        bus.g_output_ready = 1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!obs_dut_acc && k < 10);
        check("bp_fifth_accept_delay", k, 2);
        bus.dot_valid = 0;
        repeat (10) tick();

        // Reset with three entries queued and two in flight.
        bus.g_output_ready = 0;
        for (int i = 0; i < 5; i++) begin
            bus.dot_in = 200 + i; bus.dot_valid = 1;
            tick();
        end
        bus.g_output_ready = 1;
        repeat (2) tick();
        bus.g_output_ready = 0; bus.dot_valid = 0;
        check("mid_count_before_rst", bus.fifo_count, 3);
        do_reset();
        nv = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (obs_valid) nv++;
        end
        check("rst_no_valid_after", nv, 0);
        check("rst_count_after", bus.fifo_count, 0);
        check("rst_sat_after", bus.sat_flag, 0);

        // Steady push+pop at occupancy 2 over 16 samples.
        bus.g_output_ready = 0;
        for (int i = 0; i < 2; i++) begin
            bus.dot_in = 300 + i; bus.dot_valid = 1;
            tick();
        end
        bus.g_output_ready = 1;
        for (int i = 0; i < 16; i++) begin
            bus.dot_in = int'($urandom); bus.label_in = int'($urandom);
            bus.step_shift = 5'($urandom_range(0, 31));
            bus.lane_enable = 8'($urandom);
            tick();
            check("pp_count_steady", bus.fifo_count, 2);
        end
        bus.dot_valid = 0;
        repeat (10) tick();

        // Randomized traffic; a refused sample is held by the source.
        for (int c = 0; c < 400; c++) begin
            if (!(bus.dot_valid && !obs_dut_acc)) begin
                bus.dot_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 0) begin
                    bus.dot_in = int'($urandom_range(0, 2000)) - 1000;
                    bus.label_in = int'($urandom_range(0, 2000)) - 1000;
                end else begin
                    bus.dot_in = int'($urandom);
                    bus.label_in = int'($urandom);
                end
            end
            if (c % 50 == 0) bus.step_shift = 5'($urandom_range(0, 31));
            bus.g_output_ready = ($urandom_range(0, 9) < 7);
            bus.lane_enable = 8'($urandom);
            tick();
        end
        bus.dot_valid = 0; bus.g_output_ready = 1;
        repeat (12) tick();
        check("final_drain_count", bus.fifo_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
